score_disp_mux: RTL and testbench
=================================

SCORE_DISP_MUX -- requirements
Module: score_disp_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot; minimum 2.
REQ-002 Parameter LZB, default 1: 1 blanks the tens digit when it is 0.
REQ-003 Parameter BLINK_FRAMES, default 6: frames of blink after a score change; used only with SCORE_BLINK_EN.
REQ-004 Port clk, input, 1: single clock; all state on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port dig0, input, 4: units BCD digit from the score counter.
REQ-007 Port dig1, input, 4: tens BCD digit from the score counter.
REQ-008 Port blank, input, 1: when 1, all digits are off.
REQ-009 Port an, output, 2: active-low anode enables; an[1] is tens, an[0] is units.
REQ-010 Port seg, output, 7: active-low segments {g,f,e,d,c,b,a}.

Function
REQ-011 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick is asserted when the count equals REFRESH_DIV-1.
REQ-012 The scan FSM SHALL have two states, S_UNITS and S_TENS, and SHALL toggle only on the tick edge.
REQ-013 On the tick edge entering S_TENS (the frame boundary), snap SHALL load {dig1,dig0}.
REQ-014 Each displayed digit SHALL come only from snap, except in the entering-S_TENS cycle, where the incoming dig1 is used; a frame never mixes two scores.
REQ-015 an and seg SHALL be registered and SHALL be updated on the same edge as the state change; latency from a tick edge to a new output is 0 cycles after that edge.
REQ-016 In S_TENS, an SHALL be 2'b01; in S_UNITS, an SHALL be 2'b10.
REQ-017 A digit that is blanked SHALL drive an=2'b11 and seg=7'h7F for its slot.
REQ-018 Decode: digits 0-9 SHALL map to standard patterns (e.g. 2 -> 7'h24, 4 -> 7'h19, 7 -> 7'h78, 9 -> 7'h10).
REQ-019 Decode: values 10-15 SHALL show a dash, seg=7'h3F.
REQ-020 With LZB=1 and snap tens==0, the tens slot SHALL be blanked; the units digit is always shown.
REQ-021 The blank input SHALL force an=2'b11 and seg=7'h7F from the next edge, independent of tick.
REQ-022 The prescaler and FSM SHALL keep running while blank is 1.
REQ-023 When blank is released, display SHALL resume at the next tick.

Reset
REQ-024 While reset=0: an=2'b11, seg=7'h7F, prescaler=0, state=S_UNITS, snap=8'h00, blink counter=0; this SHALL take effect immediately (asynchronous).
REQ-025 The first tick after reset release SHALL occur REFRESH_DIV cycles later and SHALL enter S_TENS with a fresh snapshot.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame.

Configuration
REQ-027 Macro SCORE_BLINK_EN defined: at a frame boundary where the new snap differs from the old snap, blink_cnt SHALL load BLINK_FRAMES; otherwise a nonzero blink_cnt SHALL decrement at each boundary.
REQ-028 Macro SCORE_BLINK_EN defined: a frame with odd blink_cnt SHALL be fully blanked, and a change during a blink SHALL reload blink_cnt.
REQ-029 Macro SCORE_BLINK_EN undefined: no blink counter SHALL exist and display is suppressed only by LZB and blank.

Structure
REQ-030 Package score_disp_pkg SHALL hold the FSM state type, SEG_OFF=7'h7F, SEG_DASH=7'h3F, and the 10-entry digit pattern constant.
REQ-031 Sub-module bcd_to_seg (combinational, 4-bit in, 7-bit active-low out) SHALL implement REQ-018 and REQ-019.

Verification (REFRESH_DIV=4, BLINK_FRAMES=6)
REQ-032 Reset released, dig1=4, dig0=2 -> outputs stay an=11 for 4 cycles, then tens an=01 seg=19, then 4 cycles later units an=10 seg=24, repeating.
REQ-033 dig1=0, dig0=7, LZB=1 -> tens slot an=11 seg=7F; units slot an=10 seg=78.
REQ-034 dig0=4'hC -> units slot seg=3F.
REQ-035 Score changes from 19 to 20 during the units slot -> units slot still shows 9 (seg=10); the next frame shows 2,0; 29 and 10 never appear.
REQ-036 blank pulsed high mid-slot -> an=11 on the next edge; display resumes at the following tick; scan phase is unchanged.
REQ-037 SCORE_BLINK_EN defined, score changes 03 to 04 -> blink_cnt runs 6,5,4,3,2,1 over successive frames, frames with blink_cnt 5, 3 and 1 are fully blank, and the display is steady from blink_cnt=0; reset asserted mid-blink -> an=11 immediately.

Source files
------------

// File: rtl/score_disp_pkg.sv
// score_disp_pkg
//   Shared types and constants for the two-digit score display multiplexer.
//   Holds the scan FSM state type, the segment constants and the digit patterns.
//   The segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package score_disp_pkg;

  typedef enum logic {
    S_UNITS = 1'b0,
    S_TENS  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Entry [n] holds the pattern for digit n. The first element of the
  // concatenation is entry 9.
  localparam logic [9:0][6:0] DIGIT_SEG = {
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/score_disp_mux_bcd_to_seg.sv
// bcd_to_seg
//   Combinational BCD to 7-segment decoder with active-low outputs.
//   Digits 0-9 map to the standard patterns. The codes 10-15 are not valid
//   BCD and show a dash, so a corrupted count is visible on the display.
// Ports
//   bcd : input  [3:0]  digit value
//   seg : output [6:0]  active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg
  import score_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) begin
      seg = DIGIT_SEG[bcd];
    end
  end

endmodule

// File: rtl/score_disp_mux.sv
// score_disp_mux
//   Time-multiplexed driver for a two-digit, common-anode 7-segment score
//   display. A prescaler produces one tick every REFRESH_DIV cycles. On each
//   tick the scan FSM alternates between the tens slot and the units slot.
//   A frame is a tens slot followed by a units slot. The score is captured
//   in snap at the start of each frame, so one frame never shows digits
//   from two different scores.
//
// Parameters
//   REFRESH_DIV  : clock cycles per digit slot (minimum 2)
//   LZB          : 1 blanks the tens digit when it is 0
//   BLINK_FRAMES : frames of blink after a score change (blink build only)
// Build option
//   SCORE_BLINK_EN : when defined, a score change blinks the display. Every
//                    frame with an odd blink count is fully blank.
// Ports
//   clk       : input       clock; all state changes on its rising edge
//   reset     : input       asynchronous, active-low reset
//   dig0      : input  [3:0] units BCD digit
//   dig1      : input  [3:0] tens BCD digit
//   blank     : input       1 turns every digit off from the next edge
//   an        : output [1:0] active-low anodes, an[1]=tens, an[0]=units
//   seg       : output [6:0] active-low segments {g,f,e,d,c,b,a}
//   dbg_state : output      current scan FSM state
module score_disp_mux
  import score_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int LZB          = 1,
  parameter int BLINK_FRAMES = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  dig0,
  input  logic [3:0]  dig1,
  input  logic        blank,
  output logic [1:0]  an,
  output logic [6:0]  seg,
  output scan_state_e dbg_state
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] presc;
  logic          tick;
  scan_state_e   state, state_nxt;
  logic [7:0]    snap;
  logic          entering_tens;
  logic [3:0]    next_digit;
  logic [6:0]    next_seg;
  logic          digit_blank;
  logic          frame_blank;
  logic [1:0]    an_nxt;
  logic [6:0]    seg_nxt;

  assign tick          = (presc == CW'(REFRESH_DIV - 1));
  assign entering_tens = tick && (state == S_UNITS);
  assign dbg_state     = state;

  // Prescaler
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Scan FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_UNITS;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      state_nxt = (state == S_UNITS) ? S_TENS : S_UNITS;
    end
  end

  // Score snapshot, taken at each frame boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap <= 8'h00;
    end else if (entering_tens) begin
      snap <= {dig1, dig0};
    end
  end

  // The digit for the slot about to start. Entering tens, snap is still
  // being loaded in this cycle, so the incoming dig1 is used directly. That
  // is the same value snap captures, so the frame stays consistent.
  always_comb begin
    next_digit  = snap[3:0];
    digit_blank = 1'b0;
    if (state == S_UNITS) begin
      next_digit  = dig1;
      digit_blank = (LZB != 0) && (dig1 == 4'd0);
    end
  end

  bcd_to_seg u_dec (
    .bcd (next_digit),
    .seg (next_seg)
  );

`ifdef SCORE_BLINK_EN
  localparam int BW = (BLINK_FRAMES < 1) ? 1 : $clog2(BLINK_FRAMES + 1);

  logic [BW-1:0] blink_cnt, blink_nxt;

  always_comb begin
    blink_nxt = blink_cnt;
    if (entering_tens) begin
      if ({dig1, dig0} != snap) begin
        blink_nxt = BW'(BLINK_FRAMES);
      end else if (blink_cnt != '0) begin
        blink_nxt = blink_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_nxt;
    end
  end

  // The blink count of the frame being entered decides the tens slot. The
  // registered count, which is fixed for the whole frame, decides the units slot.
  assign frame_blank = entering_tens ? blink_nxt[0] : blink_cnt[0];
`else
  assign frame_blank = 1'b0;
`endif

  // Output registers. blank takes effect on any edge. Between ticks the
  // outputs hold, so a released blank stays dark until the next slot starts.
  always_comb begin
    an_nxt  = an;
    seg_nxt = seg;
    if (blank) begin
      an_nxt  = 2'b11;
      seg_nxt = SEG_OFF;
    end else if (tick) begin
      if (digit_blank || frame_blank) begin
        an_nxt  = 2'b11;
        seg_nxt = SEG_OFF;
      end else begin
        an_nxt  = (state == S_UNITS) ? 2'b01 : 2'b10;
        seg_nxt = next_seg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 2'b11;
      seg <= SEG_OFF;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_score_disp_mux.sv
// tb_score_disp_mux
//   Directed bench for score_disp_mux with REFRESH_DIV=4 and BLINK_FRAMES=6.
//   The blink steps are compiled only when SCORE_BLINK_EN is defined.
module tb_score_disp_mux;
  import score_disp_pkg::*;

  // Clock and reset
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  dig0 = 4'd2;
  logic [3:0]  dig1 = 4'd4;
  logic        blank = 1'b0;
  logic [1:0]  an;
  logic [6:0]  seg;
  scan_state_e dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_disp_mux #(
    .REFRESH_DIV  (4),
    .LZB          (1),
    .BLINK_FRAMES (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dig0      (dig0),
    .dig1      (dig1),
    .blank     (blank),
    .an        (an),
    .seg       (seg),
    .dbg_state (dbg_state)
  );

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] ea, input logic [6:0] es);
    n_checks++;
    assert (an === ea) else begin
      n_fail++;
      $error("FAIL %s an: got %b expected %b", tag, an, ea);
    end
    n_checks++;
    assert (seg === es) else begin
      n_fail++;
      $error("FAIL %s seg: got %h expected %h", tag, seg, es);
    end
  endtask

  task automatic check_state(input string tag, input scan_state_e es);
    n_checks++;
    assert (dbg_state === es) else begin
      n_fail++;
      $error("FAIL %s state: got %0d expected %0d", tag, dbg_state, es);
    end
  endtask

  initial begin
    // Reset state
    cyc(2);
    check("reset", 2'b11, 7'h7F);
    check_state("reset", S_UNITS);

    // Score 42: the first tick comes 4 cycles after release
    reset = 1'b1;
    cyc(3);
    check("pre_tick", 2'b11, 7'h7F);
    cyc(1);
    check("tens_4", 2'b01, 7'h19);
    check_state("tens_4", S_TENS);
    cyc(3);
    check("tens_4_hold", 2'b01, 7'h19);
    cyc(1);
    check("units_2", 2'b10, 7'h24);
    cyc(4);
    check("tens_4_again", 2'b01, 7'h19);

    // Score 07 with leading-zero blanking, changed during the tens slot
    dig1 = 4'd0; dig0 = 4'd7;
    cyc(4);
    check("units_old_snap", 2'b10, 7'h24);
    cyc(4);
    check("tens_lzb", 2'b11, 7'h7F);
    cyc(4);
    check("units_7", 2'b10, 7'h78);

    // Invalid units code shows a dash
    dig0 = 4'hC;
    cyc(4);
    check("tens_lzb_c", 2'b11, 7'h7F);
    cyc(4);
    check("units_dash", 2'b10, 7'h3F);

    // Score 19 then 20 arriving mid units slot
    dig1 = 4'd1; dig0 = 4'd9;
    cyc(4);
    check("tens_1", 2'b01, 7'h79);
    cyc(4);
    check("units_9", 2'b10, 7'h10);
    cyc(1);
    dig1 = 4'd2; dig0 = 4'd0;
    cyc(2);
    check("units_9_kept", 2'b10, 7'h10);
    cyc(1);
    check("tens_2", 2'b01, 7'h24);
    cyc(4);
    check("units_0", 2'b10, 7'h40);

    // blank pulse mid slot
    cyc(1);
    blank = 1'b1;
    cyc(1);
    check("blank_on", 2'b11, 7'h7F);
    check_state("blank_on", S_UNITS);
    blank = 1'b0;
    cyc(1);
    check("blank_released", 2'b11, 7'h7F);
    cyc(1);
    check("blank_resume", 2'b01, 7'h24);
    check_state("blank_resume", S_TENS);

    // Invalid tens code (not zero, so no leading-zero blanking)
    dig1 = 4'hA; dig0 = 4'd5;
    cyc(4);
    check("units_0_again", 2'b10, 7'h40);
    cyc(4);
    check("tens_dash", 2'b01, 7'h3F);
    cyc(4);
    check("units_5", 2'b10, 7'h12);

    // Reset mid frame acts immediately and restarts the scan
    cyc(1);
    reset = 1'b0;
    #1;
    check("reset_mid", 2'b11, 7'h7F);
    check_state("reset_mid", S_UNITS);
    cyc(2);
    dig1 = 4'd3; dig0 = 4'd8;
    reset = 1'b1;
    cyc(3);
    check("restart_pre", 2'b11, 7'h7F);
    cyc(1);
    check("restart_tens_3", 2'b01, 7'h30);
    cyc(4);
    check("restart_units_8", 2'b10, 7'h00);

`ifdef SCORE_BLINK_EN
    // Score 03: let the power-up blink finish over 7 frames
    reset = 1'b0;
    dig1 = 4'd0; dig0 = 4'd3;
    cyc(1);
    reset = 1'b1;
    cyc(56);
    check("blink_settled_3", 2'b10, 7'h30);
    // Change to 04: blink counts 6..0, odd frames dark
    dig0 = 4'd4;
    for (int k = 0; k < 7; k++) begin
      cyc(8);
      if (((6 - k) % 2) == 1) begin
        check($sformatf("blink_dark_%0d", 6 - k), 2'b11, 7'h7F);
      end else begin
        check($sformatf("blink_lit_%0d", 6 - k), 2'b10, 7'h19);
      end
    end
    cyc(8);
    check("blink_steady", 2'b10, 7'h19);
    // New change, then reset during the blink
    dig0 = 4'd5;
    cyc(8);
    check("blink_restart", 2'b10, 7'h12);
    cyc(1);
    reset = 1'b0;
    #1;
    check("blink_reset", 2'b11, 7'h7F);
    reset = 1'b1;
`endif

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
